// File: rtl/jtframe_sdram_sched_if.sv
// rtl/jtframe_sdram_sched_if.sv - host-side request/response bundle for the SDRAM scheduler
interface jtframe_sdram_sched_if;
    logic        downloading;
    logic [23:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_be;
    logic        prog_we;
    logic        prog_ack;
    logic [95:0] slot_addr;
    logic [3:0]  slot_req;
    logic [3:0]  slot_ack;
    logic [15:0] dout;
    logic        init_done;

    modport master (
        output downloading, prog_addr, prog_data, prog_be, prog_we, slot_addr, slot_req,
        input  prog_ack, slot_ack, dout, init_done
    );

    modport slave (
        input  downloading, prog_addr, prog_data, prog_be, prog_we, slot_addr, slot_req,
        output prog_ack, slot_ack, dout, init_done
    );
endinterface

// File: rtl/jtframe_sdram_sched.sv
// rtl/jtframe_sdram_sched.sv - closed-page SDR SDRAM scheduler: init, refresh, prog writes, 4 read slots
module jtframe_sdram_sched #(
    parameter int INIT_WAIT  = 9600,
    parameter int RCD        = 2,
    parameter int CAS_LAT    = 2,
    parameter int RC_WAIT    = 7,
    parameter int REF_CYCLES = 700
) (
    input  logic        clk,
    input  logic        rst_n,
    jtframe_sdram_sched_if.slave bus,
    inout  wire  [15:0] sdram_dq,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_ba,
    output logic        sdram_dqml,
    output logic        sdram_dqmh,
    output logic        sdram_ncs,
    output logic        sdram_nras,
    output logic        sdram_ncas,
    output logic        sdram_nwe,
    output logic        sdram_cke
);
    localparam logic [3:0] CMD_NOP = 4'b0111, CMD_ACT = 4'b0011, CMD_READ = 4'b0101,
                           CMD_WRITE = 4'b0100, CMD_PRE = 4'b0010, CMD_REF = 4'b0001,
                           CMD_MRS = 4'b0000;
    localparam int RD_LAT   = RCD + CAS_LAT;
    // the bank stays busy until tRC has elapsed and read data is back
    localparam int BUSY_LEN = (RC_WAIT > RD_LAT + 1) ? RC_WAIT : RD_LAT + 1;
    localparam int CNT_W    = $clog2(((INIT_WAIT > BUSY_LEN) ? INIT_WAIT : BUSY_LEN) + 1);
    localparam int RW       = $clog2(REF_CYCLES);
    localparam logic [12:0] MRS_VAL = {6'b000_0_00, 3'(CAS_LAT), 4'b0_000};

    typedef enum logic [2:0] {ST_INIT_WAIT, ST_INIT_SEQ, ST_INIT_MRS, ST_IDLE, ST_BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       init_step;
    logic [3:0]       cmd;
    logic [1:0]       dqm;
    logic [15:0]      dq_out;
    logic             dq_oe;
    logic             prog_ack, init_done;
    logic [3:0]       slot_ack;
    logic [15:0]      dout;
    logic [RW-1:0]    ref_cnt;
    logic             ref_pend, ref_wrap;
    logic [1:0]       rr, rr_idx, op_slot;
    logic             rr_any, op_read, op_ref;
    logic [8:0]       op_col;
    logic [1:0]       op_be;
    logic [15:0]      op_data;
    logic [23:0]      gnt_addr;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next = cnt + 1'b1;
    assign ref_wrap = init_done && (ref_cnt == RW'(REF_CYCLES - 1));

    // lowest offset from the round-robin pointer wins
    always_comb begin
        rr_any   = 1'b0;
        rr_idx   = rr;
        gnt_addr = '0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.slot_req[rr + 2'(i)]) begin
                rr_any = 1'b1;
                rr_idx = rr + 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (2'(i) == rr_idx) gnt_addr = bus.slot_addr[i*24 +: 24];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT_WAIT;  cnt <= '0;       init_step <= '0;
            cmd <= CMD_NOP;         sdram_a <= '0;   sdram_ba <= '0;
            dqm <= 2'b11;           dq_out <= '0;    dq_oe <= 1'b0;
            prog_ack <= 1'b0;       slot_ack <= '0;  dout <= '0;
            init_done <= 1'b0;      ref_cnt <= '0;   ref_pend <= 1'b0;
            rr <= '0;               op_slot <= '0;   op_read <= 1'b0;
            op_ref <= 1'b0;         op_col <= '0;    op_be <= '0;
            op_data <= '0;
        end else begin
            cmd      <= CMD_NOP;
            dqm      <= 2'b11;
            dq_oe    <= 1'b0;
            prog_ack <= 1'b0;
            slot_ack <= '0;
            if (init_done) begin
                if (ref_wrap) begin
                    ref_cnt  <= '0;
                    ref_pend <= 1'b1;
                end else begin
                    ref_cnt <= ref_cnt + 1'b1;
                end
            end
            case (state)
                ST_INIT_WAIT: begin
                    if (cnt == CNT_W'(INIT_WAIT - 1)) begin
                        cmd       <= CMD_PRE;
                        sdram_a   <= 13'h0400;
                        sdram_ba  <= '0;
                        cnt       <= CNT_W'(1);
                        init_step <= '0;
                        state     <= ST_INIT_SEQ;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ST_INIT_SEQ: begin
                    if (cnt == CNT_W'(RC_WAIT)) begin
                        cnt       <= CNT_W'(1);
                        init_step <= init_step + 1'b1;
                        if (init_step == 2'd2) begin
                            cmd     <= CMD_MRS;
                            sdram_a <= MRS_VAL;
                            state   <= ST_INIT_MRS;
                        end else begin
                            cmd <= CMD_REF;
                        end
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ST_INIT_MRS: begin
                    init_done <= 1'b1;
                    state     <= ST_IDLE;
                end
                ST_IDLE: begin
                    cnt <= '0;
                    if (ref_pend) begin
                        cmd    <= CMD_REF;
                        op_ref <= 1'b1;
                        state  <= ST_BUSY;
                        if (!ref_wrap) ref_pend <= 1'b0;
                    end else if (bus.downloading && bus.prog_we) begin
                        cmd      <= CMD_ACT;
                        sdram_ba <= bus.prog_addr[23:22];
                        sdram_a  <= bus.prog_addr[21:9];
                        op_col   <= bus.prog_addr[8:0];
                        op_data  <= bus.prog_data;
                        op_be    <= bus.prog_be;
                        op_ref   <= 1'b0;
                        op_read  <= 1'b0;
                        state    <= ST_BUSY;
                    end else if (!bus.downloading && rr_any) begin
                        cmd      <= CMD_ACT;
                        sdram_ba <= gnt_addr[23:22];
                        sdram_a  <= gnt_addr[21:9];
                        op_col   <= gnt_addr[8:0];
                        op_slot  <= rr_idx;
                        op_ref   <= 1'b0;
                        op_read  <= 1'b1;
                        rr       <= rr_idx + 2'd1;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt_next;
                    if (!op_ref && cnt_next == CNT_W'(RCD)) begin
                        cmd      <= op_read ? CMD_READ : CMD_WRITE;
                        sdram_a  <= {2'b00, 1'b1, 1'b0, op_col};
                        dqm      <= op_read ? 2'b00 : ~op_be;
                        dq_oe    <= !op_read;
                        dq_out   <= op_data;
                        prog_ack <= !op_read;
                    end
                    if (!op_ref && op_read && cnt_next == CNT_W'(RD_LAT)) begin
                        dout              <= sdram_dq;
                        slot_ack[op_slot] <= 1'b1;
                    end
                    if (cnt_next == CNT_W'(BUSY_LEN - 1)) state <= ST_IDLE;
                end
                default: state <= ST_INIT_WAIT;
            endcase
        end
    end

    assign {sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe} = cmd;
    assign {sdram_dqmh, sdram_dqml} = dqm;
    assign sdram_cke     = 1'b1;
    assign sdram_dq      = dq_oe ? dq_out : 16'hzzzz;
    assign bus.prog_ack  = prog_ack;
    assign bus.slot_ack  = slot_ack;
    assign bus.dout      = dout;
    assign bus.init_done = init_done;
endmodule
